// File: rtl/result_drain.sv
`default_nettype none
// ============================================================================
//  Module      : result_drain
//  Description : Drains the 8x8 matrix-multiply result RAM in address order,
//                saturates each signed word to OUT_W bits and streams it over
//                a valid/ready interface through a two-entry output buffer.
//                Also accumulates a raw checksum and a count of clipped words.
//  Revision    : 1.0 - initial release
// ============================================================================
module result_drain #(
    parameter int ENTRIES = 64,
    parameter int ADDR_W  = 6,
    parameter int IN_W    = 19,
    parameter int OUT_W   = 16,
    parameter int FIFO_D  = 2
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    done,
    output logic                    rd_en,
    output logic [ADDR_W-1:0]       rd_addr,
    input  logic [IN_W-1:0]         rd_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [OUT_W-1:0]        out_data,
    output logic [ADDR_W-1:0]       out_index,
    output logic                    out_last,
    output logic                    busy,
    output logic                    drain_done,
    output logic [IN_W+ADDR_W-1:0]  checksum,
    output logic [ADDR_W:0]         sat_count
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_FIN   = 2'd3;

    localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(ENTRIES - 1);
    localparam logic signed [IN_W-1:0] c_sat_max =
        {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [IN_W-1:0] c_sat_min =
        {{(IN_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic              r_done_q;
    logic [ADDR_W-1:0] r_addr;
    logic              r_inflight;
    logic [ADDR_W-1:0] r_inflight_addr;
    logic [OUT_W-1:0]  r_mem_data [FIFO_D];
    logic [ADDR_W-1:0] r_mem_idx  [FIFO_D];
    logic              r_wptr;
    logic              r_rptr;
    logic [1:0]        r_count;
    logic [IN_W+ADDR_W-1:0] r_checksum;
    logic [ADDR_W:0]   r_sat_count;

    logic              w_start;
    logic              w_push;
    logic              w_pop;
    logic [2:0]        w_level;
    logic              w_rd_en;
    logic              w_busy;
    logic              w_drain_done;
    logic              w_clip_hi;
    logic              w_clip_lo;
    logic [OUT_W-1:0]  w_sat_data;

    // Only a fresh rising edge of done, seen while idle, starts a drain.
    assign w_start = done & ~r_done_q & (r_state == S_IDLE);

    // Returned read data is always accepted: the issue rule guarantees room.
    assign w_push = r_inflight;
    assign w_pop  = out_valid & out_ready;

    // Buffer level at the start of next cycle, counting the read now in flight.
    // Including this cycle's pop lets a new read go out every cycle while the
    // consumer keeps up, without ever landing a push on a full buffer.
    assign w_level = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};

    assign w_clip_hi  = $signed(rd_data) > c_sat_max;
    assign w_clip_lo  = $signed(rd_data) < c_sat_min;
    assign w_sat_data = w_clip_hi ? {1'b0, {(OUT_W-1){1'b1}}} :
                        w_clip_lo ? {1'b1, {(OUT_W-1){1'b0}}} :
                                    rd_data[OUT_W-1:0];

    // State register and done edge-detect flop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_done_q <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_done_q <= done;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_state_nxt = S_FETCH;
            S_FETCH: if (w_rd_en && (r_addr == c_last_addr)) w_state_nxt = S_WAIT;
            S_WAIT:  if (w_pop && out_last) w_state_nxt = S_FIN;
            S_FIN:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State-decoded outputs: read strobe, busy and completion pulse.
    always_comb begin
        w_rd_en      = 1'b0;
        w_busy       = 1'b0;
        w_drain_done = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_busy  = 1'b1;
                w_rd_en = (w_level < 3'(FIFO_D));
            end
            S_WAIT:  w_busy = 1'b1;
            S_FIN:   w_drain_done = 1'b1;
            default: ;
        endcase
    end

    // Read address counter and in-flight tracking for the 1-cycle RAM latency.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_addr          <= '0;
            r_inflight      <= 1'b0;
            r_inflight_addr <= '0;
        end else begin
            if (w_start) begin
                r_addr <= '0;
            end else if (w_rd_en && (r_addr != c_last_addr)) begin
                r_addr <= r_addr + 1'b1;
            end
            r_inflight      <= w_rd_en;
            r_inflight_addr <= r_addr;
        end
    end

    // Two-entry output buffer holding saturated data and source address.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_D; i++) begin
                r_mem_data[i] <= '0;
                r_mem_idx[i]  <= '0;
            end
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem_data[r_wptr] <= w_sat_data;
                r_mem_idx[r_wptr]  <= r_inflight_addr;
                r_wptr             <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Raw checksum and clip counter, cleared at drain start and held after.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_checksum  <= '0;
            r_sat_count <= '0;
        end else if (w_start) begin
            r_checksum  <= '0;
            r_sat_count <= '0;
        end else if (w_push) begin
            r_checksum <= r_checksum + {{ADDR_W{rd_data[IN_W-1]}}, rd_data};
            if (w_clip_hi || w_clip_lo) begin
                r_sat_count <= r_sat_count + {{ADDR_W{1'b0}}, 1'b1};
            end
        end
    end

    assign rd_en      = w_rd_en;
    assign rd_addr    = r_addr;
    assign out_valid  = (r_count != 2'd0);
    assign out_data   = r_mem_data[r_rptr];
    assign out_index  = r_mem_idx[r_rptr];
    assign out_last   = (r_mem_idx[r_rptr] == c_last_addr) && out_valid;
    assign busy       = w_busy;
    assign drain_done = w_drain_done;
    assign checksum   = r_checksum;
    assign sat_count  = r_sat_count;

endmodule
`default_nettype wire

// File: tb/tb_result_drain.sv
`default_nettype none
// ============================================================================
//  Module      : tb_result_drain
//  Description : Directed self-checking bench for result_drain with a
//                1-cycle-latency result RAM model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_result_drain;

    localparam int ENTRIES = 64;
    localparam int ADDR_W  = 6;
    localparam int IN_W    = 19;
    localparam int OUT_W   = 16;

    logic                   clk = 1'b0;
    logic                   reset_n;
    logic                   done;
    logic                   rd_en;
    logic [ADDR_W-1:0]      rd_addr;
    logic [IN_W-1:0]        rd_data;
    logic                   out_valid;
    logic                   out_ready;
    logic [OUT_W-1:0]       out_data;
    logic [ADDR_W-1:0]      out_index;
    logic                   out_last;
    logic                   busy;
    logic                   drain_done;
    logic [IN_W+ADDR_W-1:0] checksum;
    logic [ADDR_W:0]        sat_count;

    always #5 clk = ~clk;

    result_drain #(
        .ENTRIES (ENTRIES),
        .ADDR_W  (ADDR_W),
        .IN_W    (IN_W),
        .OUT_W   (OUT_W),
        .FIFO_D  (2)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .done       (done),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_index  (out_index),
        .out_last   (out_last),
        .busy       (busy),
        .drain_done (drain_done),
        .checksum   (checksum),
        .sat_count  (sat_count)
    );

    // Result RAM model: data valid the cycle after the read strobe.
    logic signed [IN_W-1:0] ram [ENTRIES];
    always @(posedge clk) begin
        if (rd_en) rd_data <= ram[rd_addr];
    end

    int n_checks = 0;
    int n_errors = 0;
    int beat_cnt, rd_cnt, cyc, first_cyc, last_cyc, done_pulses;
    logic stalled;
    logic [OUT_W-1:0]  held_data;
    logic [ADDR_W-1:0] held_idx;
    logic signed [OUT_W-1:0] cap [ENTRIES];

    task automatic check(input string tag, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic int sat16(input int v);
        if (v > 32767)  return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    // One clock: drive ready after the edge, observe on the falling edge.
    task automatic step(input logic rdy);
        @(posedge clk);
        #1 out_ready = rdy;
        cyc++;
        @(negedge clk);
        if (rd_en) rd_cnt++;
        if (stalled) begin
            check("stall_valid", out_valid, 1);
            check("stall_data", out_data, held_data);
            check("stall_index", out_index, held_idx);
        end
        if (out_valid && out_ready) begin
            if (beat_cnt >= ENTRIES) begin
                check("extra_beat", beat_cnt, ENTRIES - 1);
            end else begin
                check("beat_index", out_index, beat_cnt);
                check("beat_data", $signed(out_data), sat16(int'(ram[beat_cnt])));
                check("beat_last", out_last, beat_cnt == ENTRIES - 1);
                cap[beat_cnt] = out_data;
            end
            if (beat_cnt == 0) first_cyc = cyc;
            last_cyc = cyc;
            beat_cnt++;
        end
        check("outstanding", (rd_cnt - beat_cnt) <= 3, 1);
        if (drain_done) begin
            done_pulses++;
            check("done_after_last", cyc - last_cyc, 1);
            check("busy_in_fin", busy, 0);
        end
        stalled   = out_valid && !out_ready;
        held_data = out_data;
        held_idx  = out_index;
    endtask

    // mode 0: ready high; 1: 1,0,0,1 pattern plus stall at beat 30;
    // 2: extra done pulse mid-drain; 3: stop after 20 beats.
    task automatic run_drain(input int mode);
        int   rdy_k = 0;
        int   stall_left = 20;
        int   budget = 0;
        logic rdy;
        done = 1'b0;
        step(1'b1);
        step(1'b1);
        beat_cnt = 0; rd_cnt = 0; stalled = 1'b0;
        first_cyc = -1; last_cyc = -100; done_pulses = 0;
        check("pre_rd_en", rd_en, 0);
        done = 1'b1;
        step(1'b1);
        check("first_rd_en", rd_en, 1);
        check("first_rd_addr", rd_addr, 0);
        check("busy_start", busy, 1);
        while (done_pulses == 0 && budget < 2000) begin
            if (mode == 3 && beat_cnt >= 20) break;
            if (mode == 2 && budget == 10) done = 1'b0;
            if (mode == 2 && budget == 13) done = 1'b1;
            if (mode == 1 && beat_cnt == 30 && stall_left > 0) begin
                rdy = 1'b0;
                stall_left--;
            end else if (mode == 1) begin
                rdy = (rdy_k % 4 == 0) || (rdy_k % 4 == 3);
                rdy_k++;
            end else begin
                rdy = 1'b1;
            end
            step(rdy);
            budget++;
        end
        if (mode != 3) begin
            check("drain_finished", done_pulses, 1);
            check("beats", beat_cnt, ENTRIES);
            check("reads", rd_cnt, ENTRIES);
            if (mode == 0) check("consecutive", last_cyc - first_cyc, ENTRIES - 1);
            step(1'b1);
            check("done_pulse_len", drain_done, 0);
            check("busy_after", busy, 0);
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_rd_en", rd_en, 0);
        check("rst_rd_addr", rd_addr, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_index", out_index, 0);
        check("rst_out_last", out_last, 0);
        check("rst_busy", busy, 0);
        check("rst_drain_done", drain_done, 0);
        check("rst_checksum", checksum, 0);
        check("rst_sat_count", sat_count, 0);
    endtask

    initial begin
        reset_n = 1'b1; done = 1'b0; out_ready = 1'b0; cyc = 0;
        stalled = 1'b0; beat_cnt = 0; rd_cnt = 0;
        for (int i = 0; i < ENTRIES; i++) ram[i] = '0;
        #2 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 check_reset_outputs();
        @(negedge clk) reset_n = 1'b1;

        // Ramp 0..63, full throughput.
        for (int i = 0; i < ENTRIES; i++) ram[i] = 19'(i);
        run_drain(0);
        check("ramp_checksum", $signed(checksum), 2016);
        check("ramp_sat", sat_count, 0);

        // Saturation corners.
        for (int i = 0; i < ENTRIES; i++) ram[i] = '0;
        ram[5] = 19'sd40000; ram[6] = -19'sd40000;
        ram[7] = 19'sd32767; ram[8] = -19'sd32768;
        run_drain(0);
        check("sat_beat5", cap[5], 32767);
        check("sat_beat6", cap[6], -32768);
        check("sat_beat7", cap[7], 32767);
        check("sat_beat8", cap[8], -32768);
        check("sat_count", sat_count, 2);
        check("sat_checksum", $signed(checksum), -1);

        // Back-pressure pattern with a long stall.
        for (int i = 0; i < ENTRIES; i++) ram[i] = 19'(i);
        run_drain(1);
        check("bp_checksum", $signed(checksum), 2016);

        // Extra done pulse mid-drain, then done held high afterwards.
        for (int i = 0; i < ENTRIES; i++) ram[i] = 19'(i - 32);
        run_drain(2);
        check("repulse_checksum", $signed(checksum), -32);
        repeat (20) step(1'b1);
        check("hold_no_reads", rd_cnt, ENTRIES);
        check("hold_no_beats", beat_cnt, ENTRIES);
        check("hold_idle", busy, 0);
        check("hold_checksum", $signed(checksum), -32);
        for (int i = 0; i < ENTRIES; i++) ram[i] = 19'(i * 100);
        run_drain(0);
        check("fresh_checksum", $signed(checksum), 201600);

        // Asynchronous reset mid-drain, then restart from address 0.
        run_drain(3);
        check("partial_beats", beat_cnt, 20);
        @(posedge clk);
        #3 reset_n = 1'b0;
        done = 1'b0;
        #1 check_reset_outputs();
        step(1'b1);
        step(1'b1);
        check("rst_hold_valid", out_valid, 0);
        check("rst_hold_busy", busy, 0);
        @(negedge clk) reset_n = 1'b1;
        run_drain(0);
        check("restart_checksum", $signed(checksum), 201600);

        // Every word at the most negative 19-bit value.
        for (int i = 0; i < ENTRIES; i++) ram[i] = -19'sd262144;
        run_drain(0);
        check("min_beat0", cap[0], -32768);
        check("min_beat63", cap[63], -32768);
        check("min_sat", sat_count, 64);
        check("min_checksum", $signed(checksum), -16777216);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
